// File: rtl/access_pkg.sv
// Shared constants for the access entry sequencer: keypad codes, LCD message
// selects and FSM state encodings.
package access_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    localparam logic [1:0] MSG_USER     = 2'b00;
    localparam logic [1:0] MSG_KEY      = 2'b01;
    localparam logic [1:0] MSG_OPEN     = 2'b10;
    localparam logic [1:0] MSG_INTRUDER = 2'b11;

    localparam logic [2:0] S_USER    = 3'd0;
    localparam logic [2:0] S_KEY     = 3'd1;
    localparam logic [2:0] S_CHECK_U = 3'd2;
    localparam logic [2:0] S_CHECK_K = 3'd3;
    localparam logic [2:0] S_OPEN    = 3'd4;
    localparam logic [2:0] S_LOCK    = 3'd5;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Decimal digit accumulator: shifts keypad digits into a binary value and
// counts them, saturating at NUM_DIGITS.
module digit_accumulator #(
    parameter int W          = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         digit_valid,
    input  logic [3:0]   digit,
    input  logic         clear,
    input  logic         load_zero,
    output logic [W-1:0] value,
    output logic [2:0]   count
);

    // Widened by 4 bits so value*10+digit cannot wrap before truncation.
    logic [W+3:0] wide;
    logic [3:0]   wide_unused_hi;
    logic [W-1:0] value_n;

    assign wide = {4'b0, value} * (W+4)'(10) + {{W{1'b0}}, digit};
    assign {wide_unused_hi, value_n} = wide;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (clear || load_zero) begin
            value <= '0;
            count <= '0;
        end else if (digit_valid && count < 3'(NUM_DIGITS)) begin
            value <= value_n;
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/access_entry_fsm.sv
// Password-entry sequencer feeding the LCD1602 controller: user ID, then key,
// then timed OPEN. Define ACCESS_LOCKOUT_EN to add the fail counter and S_LOCK.
module access_entry_fsm
    import access_pkg::*;
#(
    parameter int MAX_NUM_PASS = 9999,
    parameter int USER_ID      = 1234,
    parameter int PASSWORD     = 4321,
    parameter int NUM_DIGITS   = 4,
    parameter int OPEN_CYCLES  = 150_000_000,
    parameter int LOCK_CYCLES  = 500_000_000,
    parameter int MAX_FAILS    = 3,
    parameter int CHG_HOLD     = 1_600_000,
    localparam int W           = $clog2(MAX_NUM_PASS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic [1:0]   sel_msg,
    output logic         message_change,
    output logic [W-1:0] data_out,
    output logic [2:0]   digit_cnt,
    output logic         door_open
);

    logic [2:0]  state, state_n;
    logic [1:0]  sel_n;
    logic        door_n;
    logic        msg_wr;
    logic [31:0] timer, timer_n;
    logic [31:0] chg_cnt;

    logic in_entry, key_digit, key_clear, load_zero, entry_full;

    assign in_entry   = (state == S_USER) || (state == S_KEY);
    assign key_digit  = key_valid && in_entry && is_digit(key_code);
    assign key_clear  = key_valid && in_entry && (key_code == KEY_CLEAR);
    assign load_zero  = (state == S_CHECK_U) || (state == S_CHECK_K);
    assign entry_full = !(digit_cnt < 3'(NUM_DIGITS));

    digit_accumulator #(.W(W), .NUM_DIGITS(NUM_DIGITS)) u_acc (
        .clk        (clk),
        .reset      (reset),
        .digit_valid(key_digit),
        .digit      (key_code),
        .clear      (key_clear),
        .load_zero  (load_zero),
        .value      (data_out),
        .count      (digit_cnt)
    );

`ifdef ACCESS_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    logic [FW-1:0] fail_cnt, fail_n, fail_inc;
    assign fail_inc = fail_cnt + FW'(1);
`else
    logic lockout_unused;
    assign lockout_unused = ^{32'(LOCK_CYCLES), 32'(MAX_FAILS)};
`endif

    always_comb begin
        state_n = state;
        sel_n   = sel_msg;
        door_n  = door_open;
        timer_n = timer;
        msg_wr  = 1'b0;
`ifdef ACCESS_LOCKOUT_EN
        fail_n  = fail_cnt;
`endif
        case (state)
            S_USER, S_KEY: begin
                if (key_valid && key_code == KEY_ENTER && entry_full)
                    state_n = (state == S_USER) ? S_CHECK_U : S_CHECK_K;
            end
            S_CHECK_U: begin
                msg_wr = 1'b1;
                if (data_out == W'(USER_ID)) begin
                    state_n = S_KEY;
                    sel_n   = MSG_KEY;
                end else begin
                    state_n = S_USER;
                    sel_n   = MSG_USER;
                end
            end
            S_CHECK_K: begin
                msg_wr = 1'b1;
                if (data_out == W'(PASSWORD)) begin
                    state_n = S_OPEN;
                    sel_n   = MSG_OPEN;
                    door_n  = 1'b1;
                    timer_n = 32'(OPEN_CYCLES - 1);
`ifdef ACCESS_LOCKOUT_EN
                    fail_n  = '0;
                end else if (fail_inc == FW'(MAX_FAILS)) begin
                    state_n = S_LOCK;
                    sel_n   = MSG_INTRUDER;
                    timer_n = 32'(LOCK_CYCLES - 1);
                    fail_n  = fail_inc;
                end else begin
                    state_n = S_KEY;
                    sel_n   = MSG_KEY;
                    fail_n  = fail_inc;
                end
`else
                end else begin
                    state_n = S_KEY;
                    sel_n   = MSG_KEY;
                end
`endif
            end
            S_OPEN: begin
                if (timer == '0) begin
                    state_n = S_USER;
                    sel_n   = MSG_USER;
                    door_n  = 1'b0;
                    msg_wr  = 1'b1;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
`ifdef ACCESS_LOCKOUT_EN
            S_LOCK: begin
                if (timer == '0) begin
                    state_n = S_USER;
                    sel_n   = MSG_USER;
                    fail_n  = '0;
                    msg_wr  = 1'b1;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
`endif
            default: state_n = S_USER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_USER;
            sel_msg        <= MSG_USER;
            door_open      <= 1'b0;
            timer          <= '0;
            message_change <= 1'b0;
            chg_cnt        <= '0;
`ifdef ACCESS_LOCKOUT_EN
            fail_cnt       <= '0;
`endif
        end else begin
            state     <= state_n;
            sel_msg   <= sel_n;
            door_open <= door_n;
            timer     <= timer_n;
`ifdef ACCESS_LOCKOUT_EN
            fail_cnt  <= fail_n;
`endif
            // Any new message restarts the hold so the LCD sees a full enable period.
            if (msg_wr) begin
                message_change <= 1'b1;
                chg_cnt        <= 32'(CHG_HOLD - 1);
            end else if (chg_cnt != '0) begin
                chg_cnt <= chg_cnt - 32'd1;
            end else begin
                message_change <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_access_entry_fsm.sv
// Randomized bench for access_entry_fsm against a timestamp-based reference model.
module tb_access_entry_fsm;

    localparam int OPEN_N = 20;
    localparam int LOCK_N = 30;
    localparam int HOLD_N = 5;
    localparam int FAILS  = 3;
`ifdef ACCESS_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int P_USER = 0, P_KEY = 1, P_CU = 2, P_CK = 3, P_OPEN = 4, P_LOCK = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [1:0]  sel_msg;
    logic        message_change;
    logic [13:0] data_out;
    logic [2:0]  digit_cnt;
    logic        door_open;

    always #5 clk = ~clk;

    access_entry_fsm #(
        .MAX_NUM_PASS(9999), .USER_ID(1234), .PASSWORD(4321), .NUM_DIGITS(4),
        .OPEN_CYCLES(OPEN_N), .LOCK_CYCLES(LOCK_N), .MAX_FAILS(FAILS), .CHG_HOLD(HOLD_N)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .sel_msg(sel_msg), .message_change(message_change), .data_out(data_out),
        .digit_cnt(digit_cnt), .door_open(door_open)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: typed digits kept as a list, timing as absolute edge numbers.
    int cyc = 0;
    int phase = P_USER;
    int q[$];
    int m_sel = 0;
    int mc_end = 0;
    int leave_at = 0;
    int fails = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int qval();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit kv, input int kc);
        bit ok;
        cyc++;
        if (rst) begin
            phase = P_USER; q.delete(); m_sel = 0; mc_end = 0; fails = 0; leave_at = 0;
            return;
        end
        case (phase)
            P_USER, P_KEY: if (kv) begin
                if (kc <= 9) begin
                    if (q.size() < 4) q.push_back(kc);
                end else if (kc == 11) q.delete();
                else if (kc == 10 && q.size() == 4) phase = (phase == P_USER) ? P_CU : P_CK;
            end
            P_CU: begin
                ok = (qval() == 1234);
                q.delete();
                phase = ok ? P_KEY : P_USER;
                m_sel = ok ? 1 : 0;
                mc_end = cyc + HOLD_N;
            end
            P_CK: begin
                ok = (qval() == 4321);
                q.delete();
                mc_end = cyc + HOLD_N;
                if (ok) begin
                    phase = P_OPEN; m_sel = 2; fails = 0; leave_at = cyc + OPEN_N;
                end else begin
                    fails++;
                    if (LOCK_EN && fails == FAILS) begin
                        phase = P_LOCK; m_sel = 3; leave_at = cyc + LOCK_N;
                    end else begin
                        phase = P_KEY; m_sel = 1;
                    end
                end
            end
            default: if (cyc == leave_at) begin
                if (phase == P_LOCK) fails = 0;
                phase = P_USER; m_sel = 0; mc_end = cyc + HOLD_N;
            end
        endcase
    endtask

    task automatic step(input bit rst, input bit kv, input int kc);
        reset = rst;
        key_valid = kv;
        key_code = 4'(kc);
        @(posedge clk);
        model_step(rst, kv, kc);
        #1;
        check("sel_msg", int'(sel_msg), m_sel);
        check("message_change", int'(message_change), int'(cyc < mc_end));
        check("data_out", int'(data_out), qval());
        check("digit_cnt", int'(digit_cnt), q.size());
        check("door_open", int'(door_open), int'(phase == P_OPEN));
    endtask

    task automatic press(input int kc);
        step(1'b0, 1'b1, kc);
        step(1'b0, 1'b0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d); press(10);
    endtask

    initial begin
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 5);
        // Correct user, then correct key, through the full OPEN window.
        enter_code(1, 2, 3, 4);
        idle(8);
        enter_code(4, 3, 2, 1);
        idle(25);
        // Three wrong keys; keys pressed during lockout must be ignored.
        enter_code(1, 2, 3, 4);
        idle(3);
        for (int k = 0; k < 3; k++) begin
            enter_code(9, 9, 9, 9);
            idle(4);
        end
        press(1); press(2); press(11); idle(10); press(10);
        idle(35);
        // CLEAR mid-entry, fifth digit, short ENTER.
        press(5); press(6); press(11); press(7);
        press(8); press(9); press(1); press(2);
        press(11); press(1); press(2); press(3); press(10);
        idle(3); press(11);
        // Wrong user, then reset during OPEN.
        enter_code(1, 2, 3, 5);
        idle(8);
        enter_code(1, 2, 3, 4);
        idle(2);
        enter_code(4, 3, 2, 1);
        idle(5);
        step(1'b1, 1'b0, 0);
        idle(8);
        // Random traffic, including back-to-back keys and invalid codes.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1) step(1'b1, 1'b0, 0);
            else if (r < 6 && phase == P_USER) enter_code(1, 2, 3, 4);
            else if (r < 6 && phase == P_KEY) begin
                if ($urandom_range(0, 1) == 1) enter_code(4, 3, 2, 1);
                else enter_code(int'($urandom_range(0, 9)), 3, 2, 1);
            end else if (r < 50) step(1'b0, 1'b1, int'($urandom_range(0, 15)));
            else step(1'b0, 1'b0, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/access_entry_fsm.md
# access_entry_fsm

Password-entry sequencer that sits directly upstream of the LCD1602 controller. It consumes decoded keypad events, accumulates a 4-digit user ID and then a 4-digit key, and compares each against parameter constants. It drives the controller's `sel_msg`, `message_change` and `data_in` inputs, and optionally locks out after repeated failures.

## Interface
Parameters:
- `MAX_NUM_PASS`, 9999: largest enterable value; sets `data_out` width `W = $clog2(MAX_NUM_PASS)` (14).
- `USER_ID`, 1234: accepted user ID.
- `PASSWORD`, 4321: accepted key.
- `NUM_DIGITS`, 4: digits per entry.
- `OPEN_CYCLES`, 150_000_000: duration of the ABIERTO display, in clocks.
- `LOCK_CYCLES`, 500_000_000: duration of the INTRUSO lockout, in clocks.
- `MAX_FAILS`, 3: consecutive key mismatches that trigger lockout.
- `CHG_HOLD`, 1_600_000: clocks `message_change` stays high; this is at least one LCD enable period.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` in 4: 0–9 digit, 4'hA ENTER, 4'hB CLEAR; other codes are ignored.
- `sel_msg` out 2: 00 INGRESA USUARIO, 01 INGRESA CLAVE, 10 ABIERTO, 11 INTRUSO.
- `message_change` out 1: level request for the LCD to restart its text.
- `data_out` out W: binary value accumulated so far; connects to LCD `data_in`.
- `digit_cnt` out 3: digits entered in the current field.
- `door_open` out 1: high while in OPEN.

## Operation
- States: `S_USER`, `S_KEY`, `S_CHECK_U`, `S_CHECK_K`, `S_OPEN`, `S_LOCK`.
- Reset values: state `S_USER`, `sel_msg`=00, `message_change`=0, `data_out`=0, `digit_cnt`=0, `door_open`=0, fail count 0, timers 0.

Digit handling, in `S_USER` and `S_KEY` only:
- A digit with `digit_cnt<NUM_DIGITS` sets `data_out <= data_out*10 + digit` and increments `digit_cnt`.
- A digit with `digit_cnt==NUM_DIGITS` is ignored.
- Arithmetic is done at W+4 bits and truncated to W; overflow is impossible with 4 digits.

CLEAR:
- Zeroes `data_out` and `digit_cnt`.
- State is unchanged.

ENTER:
- With `digit_cnt<NUM_DIGITS`: ignored.
- Otherwise: go to `S_CHECK_U` from `S_USER`, or `S_CHECK_K` from `S_KEY`.

`S_CHECK_U`:
- Match → `S_KEY`, `sel_msg`=01.
- Mismatch → `S_USER`, `sel_msg` stays 00.
- Either way, clear the accumulator.

`S_CHECK_K`:
- Match → `S_OPEN`, `sel_msg`=10, fail count cleared, `door_open`=1.
- Mismatch → fail count +1. If the new count equals `MAX_FAILS`, go to `S_LOCK` with `sel_msg`=11. Otherwise go to `S_KEY`.
- Either way, clear the accumulator.

`S_OPEN`:
- Timer counts `OPEN_CYCLES` clocks, then go to `S_USER`, `sel_msg`=00, `door_open`=0.

`S_LOCK`:
- Timer counts `LOCK_CYCLES` clocks, then go to `S_USER`, `sel_msg`=00, fail count cleared.

Keys are ignored in `S_CHECK_*`, `S_OPEN` and `S_LOCK`.

`message_change`:
- Asserted on every transition that writes `sel_msg` (including 00→00 after a user mismatch).
- Held high for `CHG_HOLD` clocks.
- A new assertion during the hold restarts the hold count.

## Timing
- All outputs are registered.
- A digit strobe at edge n shows up in `data_out`/`digit_cnt` after edge n.
- ENTER at edge n puts the FSM in `S_CHECK_*` after edge n. The next state, `sel_msg` and `message_change`=1 all update at edge n+1, so latency is 2 clocks.
- Timers load at entry. With `OPEN_CYCLES`=N, the state is `S_OPEN` for exactly N clocks.
- Timer expiry and `key_valid` in the same cycle: the key is dropped.
- `reset` mid-operation: all reset values apply at the next edge, an active `message_change` hold is cancelled, and the fail count is cleared.

## Configuration
- `ACCESS_LOCKOUT_EN` defined: fail counter and `S_LOCK` are present, and the behaviour is as above.
- `ACCESS_LOCKOUT_EN` undefined: no fail counter and no `S_LOCK`. A key mismatch always returns to `S_KEY`, `sel_msg` never takes 11, and `LOCK_CYCLES`/`MAX_FAILS` are unused.

## Structure
- Package `access_pkg`: key codes (`KEY_ENTER`, `KEY_CLEAR`), `sel_msg` encodings (`MSG_USER`, `MSG_KEY`, `MSG_OPEN`, `MSG_INTRUDER`), state localparams.
- Sub-module `digit_accumulator`: digit, clear and load-zero inputs; outputs value and count. The FSM, timers and change-hold counter stay in the top.

## Test plan
Bench uses `OPEN_CYCLES`=20, `LOCK_CYCLES`=30, `CHG_HOLD`=5, `MAX_FAILS`=3.
- Reset, then keys 1,2,3,4,ENTER → `sel_msg`=01 two clocks after ENTER; `message_change` high 5 clocks; `data_out`=0.
- In `S_KEY`: keys 4,3,2,1,ENTER → `sel_msg`=10 and `door_open`=1 for 20 clocks, then `sel_msg`=00.
- Three wrong keys (9,9,9,9,ENTER each) → `sel_msg`=11 after the third; keys ignored for 30 clocks; then 00. With the macro undefined, `sel_msg` stays 01.
- Keys 5,6,CLEAR,7 → `data_out`=7, `digit_cnt`=1. A 5th digit after 4 is ignored. ENTER with 3 digits is ignored.
- Wrong user 1,2,3,5,ENTER → `sel_msg` stays 00 and `message_change` pulses 5 clocks.
- `reset` asserted during `S_OPEN` → next clock `sel_msg`=00, `door_open`=0, `message_change`=0.
